// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; the nine taps shift left on
// every accepted pixel, and win_valid flags windows that lie fully in-image.
module window3x3_gen #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9,
  output logic              win_valid
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;

  // line_a holds row r-1, line_b holds row r-2 (contents are don't-care after reset)
  logic [DATA_W-1:0] line_a [IMG_WIDTH];
  logic [DATA_W-1:0] line_b [IMG_WIDTH];
  logic [DATA_W-1:0] tap_a;
  logic [DATA_W-1:0] tap_b;

  // sof forces the accepted pixel to position (0,0); line buffers read at that column
  always_comb begin
    col_eff = col;
    row_eff = row;
    if (sof) begin
      col_eff = '0;
      row_eff = '0;
    end
    tap_a = line_a[col_eff];
    tap_b = line_b[col_eff];
  end

  // Column/row position of the next pixel, wrapping at row and frame ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_eff == COL_LAST) begin
        col <= '0;
        row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  // Line buffers: read-before-write at the current column, old line_a cascades into line_b
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line_b[col_eff] <= tap_a;
      line_a[col_eff] <= pix_in;
    end
  end

  // Window taps shift left per accepted pixel; win_valid pulses for in-image windows only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      p4        <= '0;
      p5        <= '0;
      p6        <= '0;
      p7        <= '0;
      p8        <= '0;
      p9        <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= pix_valid && (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
      if (pix_valid) begin
        p1 <= p2;
        p2 <= p3;
        p3 <= tap_b;
        p4 <= p5;
        p5 <= p6;
        p6 <= tap_a;
        p7 <= p8;
        p8 <= p9;
        p9 <= pix_in;
      end
    end
  end

endmodule
